// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared types and thermometer mapping for the segment DAC path (see DAC_SLEW_LIMIT_EN in top)
package dac_pkg;

  localparam int DAC_CODE_W = 2;
  localparam int MAX_CODE_W = 8;
  localparam int MAX_NSEG   = 2 ** MAX_CODE_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RAMP   = 2'd1,
    ST_SETTLE = 2'd2
  } dac_state_t;

  // Segment count for a given binary code width.
  function automatic int nseg_of(input int code_w);
    return 2 ** code_w;
  endfunction

  // Code k turns on segments 0..k; segment 0 is always on.
  function automatic logic [MAX_NSEG-1:0] bin2therm(input logic [MAX_CODE_W-1:0] code);
    logic [MAX_NSEG-1:0] t;
    for (int i = 0; i < MAX_NSEG; i++) begin
      t[i] = (i <= int'(code));
    end
    return t;
  endfunction

endpackage

// File: rtl/dac_bin2therm.sv
// rtl/dac_bin2therm.sv - combinational binary to thermometer decoder
module dac_bin2therm
  import dac_pkg::*;
#(
  parameter  int CODE_W = DAC_CODE_W,
  localparam int NSEG   = nseg_of(CODE_W)
) (
  input  logic [CODE_W-1:0] i_code,
  output logic [NSEG-1:0]   o_therm
);

  logic [MAX_CODE_W-1:0] w_code_ext;
  logic [MAX_NSEG-1:0]   w_therm_all;
  logic                  w_unused_hi;

  assign w_code_ext  = MAX_CODE_W'(i_code);
  assign w_therm_all = bin2therm(w_code_ext);
  assign o_therm     = w_therm_all[NSEG-1:0];
  // Segments above NSEG are always zero for a CODE_W-bit code and are dropped.
  assign w_unused_hi = ^w_therm_all;

endmodule

// File: rtl/dac_thermo_driver.sv
// rtl/dac_thermo_driver.sv - handshaked thermometer DAC driver with settle timer, optional slew limit via DAC_SLEW_LIMIT_EN
module dac_thermo_driver
  import dac_pkg::*;
#(
  parameter  int CODE_W        = DAC_CODE_W,
  parameter  int SETTLE_CYCLES = 4,
  parameter  int STEP_CYCLES   = 2,
  localparam int NSEG          = nseg_of(CODE_W)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [CODE_W-1:0] code_in,
  input  logic              code_valid,
  output logic              code_ready,
  output logic [NSEG-1:0]   therm_out,
  output logic [CODE_W-1:0] cur_code,
  output logic              busy,
  output logic              settled
);

  // One counter serves both the step interval and the settle interval.
  localparam int CNT_MAX = (SETTLE_CYCLES > STEP_CYCLES) ? SETTLE_CYCLES : STEP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  dac_state_t        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CODE_W-1:0] r_cur_code;
  logic [NSEG-1:0]   r_therm;
  logic              r_ready;
  logic              r_busy;
  logic              r_settled;
  logic [CODE_W-1:0] w_code_next;
  logic [NSEG-1:0]   w_therm_next;
  logic              w_accept;

`ifdef DAC_SLEW_LIMIT_EN
  localparam logic [CNT_W-1:0] STEP_LOAD = CNT_W'(STEP_CYCLES - 1);

  logic [CODE_W-1:0] r_target;

  function automatic logic [CODE_W-1:0] step_toward(input logic [CODE_W-1:0] cur,
                                                    input logic [CODE_W-1:0] tgt);
    if (tgt > cur)      return cur + CODE_W'(1);
    else if (tgt < cur) return cur - CODE_W'(1);
    else                return cur;
  endfunction
`endif

  assign w_accept = (r_state == ST_IDLE) && code_valid;

  // Code to apply on the next edge: a single step when slew-limited, otherwise a direct jump.
  always_comb begin
    w_code_next = r_cur_code;
`ifdef DAC_SLEW_LIMIT_EN
    if (w_accept) begin
      w_code_next = step_toward(r_cur_code, code_in);
    end else if ((r_state == ST_RAMP) && (r_cnt == '0)) begin
      w_code_next = step_toward(r_cur_code, r_target);
    end
`else
    if (w_accept) begin
      w_code_next = code_in;
    end
`endif
  end

  dac_bin2therm #(
    .CODE_W (CODE_W)
  ) u_bin2therm (
    .i_code  (w_code_next),
    .o_therm (w_therm_next)
  );

  // Control FSM with registered drive and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_cur_code <= '0;
      r_therm    <= NSEG'(1);
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_settled  <= 1'b1;
`ifdef DAC_SLEW_LIMIT_EN
      r_target   <= '0;
`endif
    end else begin
      r_cur_code <= w_code_next;
      r_therm    <= w_therm_next;
      case (r_state)
        ST_IDLE: begin
          if (code_valid) begin
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
            r_settled <= 1'b0;
`ifdef DAC_SLEW_LIMIT_EN
            r_target  <= code_in;
            if (w_code_next == code_in) begin
              r_state <= ST_SETTLE;
              r_cnt   <= SETTLE_LOAD;
            end else begin
              r_state <= ST_RAMP;
              r_cnt   <= STEP_LOAD;
            end
`else
            r_state   <= ST_SETTLE;
            r_cnt     <= SETTLE_LOAD;
`endif
          end
        end
`ifdef DAC_SLEW_LIMIT_EN
        ST_RAMP: begin
          if (r_cnt == '0) begin
            if (w_code_next == r_target) begin
              r_state <= ST_SETTLE;
              r_cnt   <= SETTLE_LOAD;
            end else begin
              r_cnt   <= STEP_LOAD;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
`endif
        ST_SETTLE: begin
          if (r_cnt == '0) begin
            r_state   <= ST_IDLE;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_settled <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_ready   <= 1'b1;
          r_busy    <= 1'b0;
          r_settled <= 1'b1;
        end
      endcase
    end
  end

  assign code_ready = r_ready;
  assign busy       = r_busy;
  assign settled    = r_settled;
  assign therm_out  = r_therm;
  assign cur_code   = r_cur_code;

endmodule

// File: tb/tb_dac_thermo_driver.sv
// tb/tb_dac_thermo_driver.sv - directed self-checking bench for dac_thermo_driver
module tb_dac_thermo_driver;

  localparam int CW   = 2;
  localparam int NS   = 4;
  localparam int SET  = 4;
  localparam int STEP = 2;
`ifdef DAC_SLEW_LIMIT_EN
  localparam bit SLEW = 1'b1;
`else
  localparam bit SLEW = 1'b0;
`endif

  logic          clk;
  logic          reset_n;
  logic [CW-1:0] code_in;
  logic          code_valid;
  logic          code_ready;
  logic [NS-1:0] therm_out;
  logic [CW-1:0] cur_code;
  logic          busy;
  logic          settled;

  int n_checks = 0;
  int n_errors = 0;

  dac_thermo_driver #(
    .CODE_W        (CW),
    .SETTLE_CYCLES (SET),
    .STEP_CYCLES   (STEP)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .code_in    (code_in),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .therm_out  (therm_out),
    .cur_code   (cur_code),
    .busy       (busy),
    .settled    (settled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int therm_of(input int c);
    return (1 << (c + 1)) - 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_therm"}, 32'(therm_out), 32'h1);
    check({tag, "_cur"}, 32'(cur_code), 32'h0);
    check({tag, "_ready"}, 32'(code_ready), 32'h1);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_settled"}, 32'(settled), 32'h1);
  endtask

  task automatic wait_ready(input int max_cycles);
    int n;
    n = 0;
    while (!code_ready && n < max_cycles) begin
      tick();
      n++;
    end
    check("wait_ready_bound", 32'(code_ready), 32'h1);
  endtask

  // Send one code and follow every cycle until code_ready returns.
  task automatic run_xfer(input int from, input int to);
    int d, ad, lat, steps, exp_c;
    d   = to - from;
    ad  = (d < 0) ? -d : d;
    lat = (SLEW && ad > 0) ? (ad - 1) * STEP + SET : SET;
    code_in    = CW'(to);
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    for (int n = 0; n <= lat; n++) begin
      if (n > 0) tick();
      if (SLEW) steps = (ad == 0) ? 0 : ((1 + n / STEP) < ad ? (1 + n / STEP) : ad);
      else      steps = ad;
      exp_c = from + ((d < 0) ? -steps : steps);
      check("xfer_therm", 32'(therm_out), 32'(therm_of(exp_c)));
      check("xfer_cur", 32'(cur_code), 32'(exp_c));
      check("xfer_ready", 32'(code_ready), 32'(n >= lat));
      check("xfer_busy", 32'(busy), 32'(n < lat));
      check("xfer_settled", 32'(settled), 32'(n >= lat));
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    code_in    = '0;
    code_valid = 1'b0;
    repeat (3) tick();
    check_reset_vals("reset");
    reset_n = 1'b1;
    tick();
    check_reset_vals("post_release");

    // Upward full-scale move, downward move, same code, and down to zero.
    run_xfer(0, 3);
    run_xfer(3, 1);
    run_xfer(1, 1);
    run_xfer(1, 0);
    run_xfer(0, 0);

    // A single valid pulse while busy is dropped.
    code_in    = 2'd2;
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    check("bp_busy", 32'(busy), 32'h1);
    code_in    = 2'd1;
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    wait_ready(40);
    check("bp_cur", 32'(cur_code), 32'h2);
    check("bp_therm", 32'(therm_out), 32'h7);

    // Holding valid through a busy period is accepted exactly once.
    code_in    = 2'd3;
    code_valid = 1'b1;
    tick();
    code_in = 2'd1;
    wait_ready(40);
    tick();
    code_valid = 1'b0;
    check("hold_busy", 32'(busy), 32'h1);
    wait_ready(40);
    check("hold_cur", 32'(cur_code), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_idle_ready", 32'(code_ready), 32'h1);
      check("hold_idle_cur", 32'(cur_code), 32'h1);
    end

    // Reset in the middle of a transfer takes effect without a clock edge.
    run_xfer(1, 0);
    code_in    = 2'd3;
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_reset_therm", 32'(therm_out), 32'h1);
      check("post_reset_ready", 32'(code_ready), 32'h1);
    end
    run_xfer(0, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
